// File: rtl/pixl2sym_ctrl_pkg.sv
// Shared definitions for the pixel-to-symbol kernel control slice.
//   - seq_state_e  : top sequencer FSM states
//   - TRIP_W_DEF / WDOG_W_DEF : default widths for trip counts and watchdog
//   - STG*_IN/OUT  : stall_src encodings, {stage, stream}
//   - stall_code() : maps a stage index and its blocked bits to a stall_src code
package pixl2sym_ctrl_pkg;

  localparam int TRIP_W_DEF = 16;
  localparam int WDOG_W_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_START1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  localparam logic [1:0] STG0_IN  = 2'd0;
  localparam logic [1:0] STG0_OUT = 2'd1;
  localparam logic [1:0] STG1_IN  = 2'd2;
  localparam logic [1:0] STG1_OUT = 2'd3;

  // Lowest set blocked bit wins: data_in (bit0) is reported ahead of data_out.
  function automatic logic [1:0] stall_code(input logic stage, input logic [1:0] blk);
    logic [1:0] code;
    if (stage) code = blk[0] ? STG1_IN : STG1_OUT;
    else       code = blk[0] ? STG0_IN : STG0_OUT;
    return code;
  endfunction

endpackage

// File: rtl/pixl2sym_stall_wdog.sv
// Stall watchdog for the active loop stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   blocked[1:0] : active stage's blocked bits, already forced to 0 when no
//                  stage is active or the active stage reports idle
//   stage        : active stage index (0 = pixel unpack, 1 = symbol emit)
//   cnt_clr      : clear the consecutive-blocked counter (state change)
//   arm_clr      : new run accepted; clear counter, sticky flag and source
//   stall_flag   : sticky alarm, registered
//   stall_src    : {stage, stream} captured when the alarm rose, registered
module pixl2sym_stall_wdog
  import pixl2sym_ctrl_pkg::*;
#(
  parameter int WDOG_W     = WDOG_W_DEF,
  parameter int WDOG_LIMIT = (2**20) - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] blocked,
  input  logic       stage,
  input  logic       cnt_clr,
  input  logic       arm_clr,
  output logic       stall_flag,
  output logic [1:0] stall_src
);

  localparam logic [WDOG_W-1:0] LIMIT_C = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic [1:0]        src_q, src_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    src_d  = src_q;
    if (arm_clr) begin
      cnt_d  = '0;
      flag_d = 1'b0;
      src_d  = '0;
    end else begin
      if (cnt_clr || (blocked == 2'b00)) begin
        cnt_d = '0;
      end else if (cnt_q != LIMIT_C) begin
        cnt_d = cnt_q + 1'b1;
      end
      // The flag rises on the same edge the counter reaches the limit, so it
      // is visible exactly WDOG_LIMIT cycles after the first blocked cycle.
      // cnt_d can only equal the limit while blocked is non-zero.
      if (!flag_q && (cnt_d == LIMIT_C)) begin
        flag_d = 1'b1;
        src_d  = stall_code(stage, blocked);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      src_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      src_q  <= src_d;
    end
  end

  assign stall_flag = flag_q;
  assign stall_src  = src_q;

endmodule

// File: rtl/pixl2sym_loop_sequencer.sv
// Top-level control for the pixel-to-symbol kernel. Runs stage 0 (pixel
// unpack) then stage 1 (symbol emit), handing each its latched trip count,
// and watches the active stage's stream-blocked flags for stalls.
// Ports:
//   ap_clk, ap_rst_n            : clock, asynchronous active-low reset
//   ap_start/ap_done/ap_ready/ap_idle : block-level ap_ctrl_hs control
//   cfg_n_pix, cfg_n_sym        : trip counts, latched when a run is accepted
//   grpN_ap_start/ready/done/idle : ap_ctrl_hs to loop stage N
//   grpN_trip                   : latched trip count for stage N
//   grpN_blk                    : stage N blocked flags {data_out, data_in}
//   stall_flag, stall_src       : sticky stall alarm and its source
//   dbg_state                   : current sequencer state (seq_state_e encoding)
// All outputs come straight from flops.
//
// Handshake: a stage start request is raised in START* and held until a
// clock edge sees the stage's ap_ready high; the stage's ap_done is a
// one-cycle pulse that may coincide with ap_ready. A done pulse from a stage
// that is not currently being run is ignored. Towards the host, ap_start is
// sampled only in IDLE, and ap_done/ap_ready pulse together for one cycle.
module pixl2sym_loop_sequencer
  import pixl2sym_ctrl_pkg::*;
#(
  parameter int TRIP_W     = TRIP_W_DEF,
  parameter int WDOG_W     = WDOG_W_DEF,
  parameter int WDOG_LIMIT = (2**20) - 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic [TRIP_W-1:0] cfg_n_pix,
  input  logic [TRIP_W-1:0] cfg_n_sym,
  output logic              grp0_ap_start,
  input  logic              grp0_ap_ready,
  input  logic              grp0_ap_done,
  input  logic              grp0_ap_idle,
  output logic [TRIP_W-1:0] grp0_trip,
  input  logic [1:0]        grp0_blk,
  output logic              grp1_ap_start,
  input  logic              grp1_ap_ready,
  input  logic              grp1_ap_done,
  input  logic              grp1_ap_idle,
  output logic [TRIP_W-1:0] grp1_trip,
  input  logic [1:0]        grp1_blk,
  output logic              stall_flag,
  output logic [1:0]        stall_src,
  output logic [2:0]        dbg_state
);

  seq_state_e        state_q, state_d;
  seq_state_e        after0;
  logic [TRIP_W-1:0] trip0_q, trip0_d;
  logic [TRIP_W-1:0] trip1_q, trip1_d;
  logic              ap_done_q, ap_done_d;
  logic              ap_idle_q, ap_idle_d;
  logic              g0_start_q, g0_start_d;
  logic              g1_start_q, g1_start_d;
  logic              start_acc;

  // Stage 1 is skipped entirely when its trip count is zero.
  assign after0 = (trip1_q != '0) ? ST_START1 : ST_DONE;

  always_comb begin
    state_d   = state_q;
    trip0_d   = trip0_q;
    trip1_d   = trip1_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          start_acc = 1'b1;
          trip0_d   = cfg_n_pix;
          trip1_d   = cfg_n_sym;
          if (cfg_n_pix != '0)      state_d = ST_START0;
          else if (cfg_n_sym != '0) state_d = ST_START1;
          else                      state_d = ST_DONE;
        end
      end
      ST_START0: begin
        if (grp0_ap_ready) state_d = grp0_ap_done ? after0 : ST_WAIT0;
      end
      ST_WAIT0: begin
        if (grp0_ap_done) state_d = after0;
      end
      ST_START1: begin
        if (grp1_ap_ready) state_d = grp1_ap_done ? ST_DONE : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (grp1_ap_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    ap_done_d  = (state_d == ST_DONE);
    ap_idle_d  = (state_d == ST_IDLE);
    g0_start_d = (state_d == ST_START0);
    g1_start_d = (state_d == ST_START1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      trip0_q    <= '0;
      trip1_q    <= '0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      g0_start_q <= 1'b0;
      g1_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trip0_q    <= trip0_d;
      trip1_q    <= trip1_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
      g0_start_q <= g0_start_d;
      g1_start_q <= g1_start_d;
    end
  end

  // Watchdog feed: only the stage currently being run counts, and only while
  // it reports itself busy.
  logic       stage_sel;
  logic       stage_act;
  logic [1:0] blk_act;
  logic       idle_act;
  logic [1:0] wdog_blocked;

  assign stage_sel    = (state_q == ST_START1) || (state_q == ST_WAIT1);
  assign stage_act    = stage_sel || (state_q == ST_START0) || (state_q == ST_WAIT0);
  assign blk_act      = stage_sel ? grp1_blk : grp0_blk;
  assign idle_act     = stage_sel ? grp1_ap_idle : grp0_ap_idle;
  assign wdog_blocked = (stage_act && !idle_act) ? blk_act : 2'b00;

  pixl2sym_stall_wdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .blocked    (wdog_blocked),
    .stage      (stage_sel),
    .cnt_clr    (state_d != state_q),
    .arm_clr    (start_acc),
    .stall_flag (stall_flag),
    .stall_src  (stall_src)
  );

  assign ap_done       = ap_done_q;
  assign ap_ready      = ap_done_q;
  assign ap_idle       = ap_idle_q;
  assign grp0_ap_start = g0_start_q;
  assign grp1_ap_start = g1_start_q;
  assign grp0_trip     = trip0_q;
  assign grp1_trip     = trip1_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/pixl2sym_loop_sequencer.md
# pixl2sym_loop_sequencer

Control block for the pixel-to-symbol kernel. It sequences the kernel's two pipelined loop stages, pixel unpack (stage 0) then symbol emit (stage 1), through ap_ctrl_hs handshakes, and passes each stage its trip count. It also runs a stall watchdog on the stages' AXI-Stream blocking signals. It sits between the top-level block-level control port and the two loop-stage instances, replacing HLS-generated top FSM sequencing so trip counts and stall reporting are under explicit control.

## Interface
- TRIP_W, 16, width of per-stage trip counts
- WDOG_W, 20, width of watchdog counter
- WDOG_LIMIT, 2**20-1, consecutive blocked cycles that raise stall_flag (must fit WDOG_W, ≥1)

Ports:
- ap_clk  in  1  single clock, all logic rising-edge
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  top-level start (level, ap_ctrl_hs)
- ap_done  out  1  one-cycle pulse, run complete
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high while in IDLE
- cfg_n_pix  in  TRIP_W  stage-0 trip count, latched on start accept
- cfg_n_sym  in  TRIP_W  stage-1 trip count, latched on start accept
- grp0_ap_start / grp1_ap_start  out  1  stage start requests
- grp0_ap_ready / grp1_ap_ready  in  1  stage accepted start
- grp0_ap_done / grp1_ap_done  in  1  stage finished (pulse)
- grp0_ap_idle / grp1_ap_idle  in  1  stage idle
- grp0_trip / grp1_trip  out  TRIP_W  latched trip counts, stable for whole run
- grp0_blk / grp1_blk  in  2  per-stage stream blocked flags, bit0 = data_in, bit1 = data_out
- stall_flag  out  1  sticky watchdog alarm
- stall_src  out  2  {stage, stream} of first-seen blocked stream at alarm

## Operation
- States: IDLE, START0, WAIT0, START1, WAIT1, DONE.
- IDLE: on ap_start=1, latch cfg_n_pix and cfg_n_sym into grp0_trip and grp1_trip, then clear stall_flag, stall_src and the watchdog counter.
  - n_pix≠0 → START0.
  - n_pix=0, n_sym≠0 → START1.
  - Both 0 → DONE.
- START0: grp0_ap_start=1 until grp0_ap_ready=1.
  - If grp0_ap_done is high in the same cycle → next stage (START1, or DONE if n_sym=0).
  - Otherwise → WAIT0.
- WAIT0: grp0_ap_start=0. On grp0_ap_done → START1 (n_sym≠0) or DONE.
- START1/WAIT1: same as START0/WAIT0 for stage 1. Stage-1 done → DONE.
- DONE: ap_done=ap_ready=1 for one cycle → IDLE. ap_start still high in IDLE starts a new run the following cycle.
- Active stage: 0 in START0/WAIT0, 1 in START1/WAIT1, none otherwise.
- Watchdog counter:
  - Increments by 1 each cycle when the active stage has any blk bit set and its ap_idle=0.
  - Clears on any cycle where that condition is false, and on every state change.
  - Saturates at WDOG_LIMIT.
  - Counter reaching WDOG_LIMIT with stall_flag=0: set stall_flag and load stall_src = {stage, lowest set blk bit index}.
  - stall_flag stays set until the next start is accepted. Sequencing is not aborted.
- A grp*_ap_done arriving in a state that does not expect it is ignored.

## Timing
- Reset values: ap_done=0, ap_ready=0, ap_idle=1, grp*_ap_start=0, grp*_trip=0, stall_flag=0, stall_src=0. State=IDLE, counter=0.
- Reset asserted mid-run returns to IDLE immediately (asynchronously) and clears all outputs to reset values.
- All outputs are registered.
- Start accept at edge N: grp0_ap_start=1 from cycle N+1, and grp*_trip are valid from N+1.
- A stage done at edge M, next stage present: next grp*_ap_start=1 from M+1.
- Final stage done at edge M: ap_done pulses in cycle M+1. ap_idle=1 from M+2.
- Both trip counts 0: ap_done in cycle N+1.
- stall_flag rises exactly WDOG_LIMIT cycles after the first blocked cycle of an unbroken blocked run.

## Structure
- Shared package pixl2sym_ctrl_pkg holds:
  - state enum
  - TRIP_W and WDOG_W defaults
  - stall_src encoding constants: STG0_IN=0, STG0_OUT=1, STG1_IN=2, STG1_OUT=3
- One sub-module, pixl2sym_stall_wdog: counter, saturation, sticky flag and source capture. Inputs are blocked, clear and active-stage index.

## Test plan
- n_pix=8, n_sym=6, stage ready the cycle after start and done 10 cycles later → grp0 start 1 cycle, grp1 start after grp0 done+1, ap_done one pulse, grp0_trip=8, grp1_trip=6.
- n_pix=0, n_sym=5 → grp0_ap_start never asserts; grp1_ap_start in cycle after accept.
- n_pix=0, n_sym=0 → ap_done/ap_ready pulse 1 cycle after accept, no stage starts.
- WDOG_LIMIT=16, grp1_blk=2'b10 held 16 cycles during WAIT1, grp1_ap_idle=0 → stall_flag=1 at cycle 16, stall_src=3. A 15-cycle block then 1 clear cycle → no flag.
- ap_rst_n pulled low during WAIT0 → all outputs at reset values immediately. New ap_start after release runs normally with stall_flag=0.
- ap_ready and ap_done same cycle from grp0 in START0 → skips WAIT0, grp1_ap_start next cycle.
